// File: rtl/unidad_busqueda_pkg.sv
// Shared types and constants for the instruction fetch stage.
package paquete_busqueda;
  localparam int ANCHO_PC_DEF    = 64;
  localparam int ANCHO_INSTR_DEF = 32;
  localparam int INCREMENTO_PC   = 4;

  typedef enum logic [1:0] {
    PEDIR,
    ESPERAR,
    DESCARTAR,
    DETENIDO
  } estado_busqueda_t;
endpackage

// File: rtl/unidad_busqueda_registro_if_id.sv
// One-entry IF/ID slot: a flush wins over a load, and a load wins over a consume.
module registro_if_id
  import paquete_busqueda::*;
#(
  parameter int ANCHO_PC    = ANCHO_PC_DEF,
  parameter int ANCHO_INSTR = ANCHO_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   i_cargar,
  input  logic                   i_consumir,
  input  logic                   i_vaciar,
  input  logic [ANCHO_INSTR-1:0] i_instr,
  input  logic [ANCHO_PC-1:0]    i_pc,
  output logic [ANCHO_INSTR-1:0] o_instr,
  output logic [ANCHO_PC-1:0]    o_pc,
  output logic                   o_valido
);
  logic [ANCHO_INSTR-1:0] r_instr;
  logic [ANCHO_PC-1:0]    r_pc;
  logic                   r_valido;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_instr  <= '0;
      r_pc     <= '0;
      r_valido <= 1'b0;
    end else if (i_vaciar) begin
      r_valido <= 1'b0;
    end else if (i_cargar) begin
      r_instr  <= i_instr;
      r_pc     <= i_pc;
      r_valido <= 1'b1;
    end else if (i_consumir) begin
      r_valido <= 1'b0;
    end
  end

  assign o_instr  = r_instr;
  assign o_pc     = r_pc;
  assign o_valido = r_valido;
endmodule

// File: rtl/unidad_busqueda.sv
// Fetch stage: PC, single-outstanding imem request FSM and IF/ID slot.
// Optional TRAP_DESALINEADO_EN: misaligned redirect targets raise err_desalineado and halt fetch.
module unidad_busqueda
  import paquete_busqueda::*;
#(
  parameter int                  ANCHO_PC    = ANCHO_PC_DEF,
  parameter int                  ANCHO_INSTR = ANCHO_INSTR_DEF,
  parameter logic [ANCHO_PC-1:0] PC_RESET    = '0
) (
  input  logic                   clk,
  input  logic                   reset_L,
  output logic                   imem_req,
  output logic [ANCHO_PC-1:0]    imem_dir,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [ANCHO_INSTR-1:0] imem_dato,
  output logic [ANCHO_INSTR-1:0] Instruccion,
  output logic [ANCHO_PC-1:0]    pc_out,
  output logic                   valido,
  input  logic                   listo,
  input  logic                   salto_tomado,
  input  logic [ANCHO_PC-1:0]    pc_salto,
  input  logic [ANCHO_PC-1:0]    Inmediato
`ifdef TRAP_DESALINEADO_EN
  ,
  output logic                   err_desalineado
`endif
);
  estado_busqueda_t    r_estado, w_estado_next;
  logic [ANCHO_PC-1:0] r_pc, r_pc_pend;
  logic [ANCHO_PC-1:0] w_objetivo_bruto, w_objetivo;
  logic                w_valido, w_libre, w_concedido, w_cargar, w_consumir, w_detener;

  assign w_objetivo_bruto = pc_salto + Inmediato;

`ifdef TRAP_DESALINEADO_EN
  logic r_err;
  logic w_desalineado;

  assign w_objetivo    = w_objetivo_bruto;
  assign w_desalineado = salto_tomado && (r_estado != DETENIDO) && (|w_objetivo_bruto[1:0]);
  // Sticky flag doubles as the "halt after the pending response" marker.
  assign w_detener     = r_err || w_desalineado;
  assign err_desalineado = r_err;

  always_ff @(posedge clk) begin
    if (!reset_L)          r_err <= 1'b0;
    else if (w_desalineado) r_err <= 1'b1;
  end
`else
  assign w_objetivo = w_objetivo_bruto & ~ANCHO_PC'(3);
  assign w_detener  = 1'b0;
`endif

  assign w_libre     = !w_valido || listo;
  assign w_concedido = imem_req && imem_gnt;
  assign w_cargar    = (r_estado == ESPERAR) && imem_rvalid && !salto_tomado;
  assign w_consumir  = w_valido && listo;
  assign imem_dir    = r_pc;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_estado  <= PEDIR;
      r_pc      <= PC_RESET;
      r_pc_pend <= '0;
    end else begin
      r_estado <= w_estado_next;
      if (salto_tomado && (r_estado != DETENIDO)) begin
        r_pc <= w_objetivo;
      end else if (w_concedido) begin
        r_pc_pend <= r_pc;
        r_pc      <= r_pc + ANCHO_PC'(INCREMENTO_PC);
      end
    end
  end

  always_comb begin
    w_estado_next = r_estado;
    unique case (r_estado)
      PEDIR: begin
        if (salto_tomado)     w_estado_next = w_detener ? DETENIDO : PEDIR;
        else if (w_concedido) w_estado_next = ESPERAR;
      end
      ESPERAR: begin
        if (imem_rvalid)       w_estado_next = w_detener ? DETENIDO : PEDIR;
        else if (salto_tomado) w_estado_next = DESCARTAR;
      end
      DESCARTAR: begin
        if (imem_rvalid) w_estado_next = w_detener ? DETENIDO : PEDIR;
      end
      DETENIDO: w_estado_next = DETENIDO;
      default:  w_estado_next = PEDIR;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (reset_L && (r_estado == PEDIR)) begin
      imem_req = w_libre && !salto_tomado;
    end
  end

  registro_if_id #(
    .ANCHO_PC   (ANCHO_PC),
    .ANCHO_INSTR(ANCHO_INSTR)
  ) u_registro_if_id (
    .clk       (clk),
    .reset_L   (reset_L),
    .i_cargar  (w_cargar),
    .i_consumir(w_consumir),
    .i_vaciar  (salto_tomado),
    .i_instr   (imem_dato),
    .i_pc      (r_pc_pend),
    .o_instr   (Instruccion),
    .o_pc      (pc_out),
    .o_valido  (w_valido)
  );

  assign valido = w_valido;
endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: directed scenarios plus random traffic against a flag-level fetch model.
module tb_unidad_busqueda;
  logic        clk = 1'b0;
  logic        reset_L, imem_req, imem_gnt, imem_rvalid, valido, listo, salto_tomado;
  logic [63:0] imem_dir, pc_out, pc_salto, Inmediato;
  logic [31:0] imem_dato, Instruccion;
`ifdef TRAP_DESALINEADO_EN
  logic        err_desalineado;
`endif

  always #5 clk = ~clk;

  unidad_busqueda dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .imem_req    (imem_req),
    .imem_dir    (imem_dir),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_dato   (imem_dato),
    .Instruccion (Instruccion),
    .pc_out      (pc_out),
    .valido      (valido),
    .listo       (listo),
    .salto_tomado(salto_tomado),
    .pc_salto    (pc_salto),
    .Inmediato   (Inmediato)
`ifdef TRAP_DESALINEADO_EN
    ,
    .err_desalineado(err_desalineado)
`endif
  );

  int n_eval = 0;
  int n_fallos = 0;

  task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_eval++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  // Reference model: PC, one outstanding fetch with a "discard" mark, one-entry slot.
  logic [63:0] m_pc, m_pend_pc, m_pcout;
  logic [31:0] m_instr;
  bit          m_out, m_disc, m_v, m_det;

  // Memory environment
  bit          mem_pend, dato_fijo, espurio_en;
  int          mem_cnt;
  logic [63:0] mem_addr;
  logic [63:0] dirs[$];

  function automatic logic [31:0] dato_de(input logic [63:0] a);
    if (dato_fijo) return 32'h01400013;
    return (a[31:0] * 32'h9E3779B1) ^ 32'h00A50013;
  endfunction

  task automatic reset_modelo();
    m_pc = 64'h0; m_pend_pc = '0; m_pcout = '0; m_instr = '0;
    m_out = 0; m_disc = 0; m_v = 0; m_det = 0;
    mem_pend = 0; mem_cnt = 0;
  endtask

  task automatic ciclo(input bit rst, input bit l, input bit g, input bit s,
                       input logic [63:0] ps, input logic [63:0] im, input int lat);
    bit rv, rv_real, exp_req, conc_dut, conc_m;
    logic [63:0] tgt;
    @(negedge clk);
    reset_L = rst; listo = l; imem_gnt = g; salto_tomado = s; pc_salto = ps; Inmediato = im;
    rv_real = mem_pend && (mem_cnt == 0);
    rv = rv_real;
    if (rv_real) imem_dato = dato_de(mem_addr);
    else begin
      imem_dato = $urandom;
      if (!mem_pend && espurio_en && ($urandom_range(3) == 0)) rv = 1;
    end
    imem_rvalid = rv;
    #1;
    exp_req = rst && !m_out && !m_det && (!m_v || l) && !s;
    comprobar("imem_req", imem_req, exp_req);
    if (exp_req) comprobar("imem_dir", imem_dir, m_pc);
    comprobar("valido", valido, m_v);
    comprobar("Instruccion", Instruccion, m_instr);
    comprobar("pc_out", pc_out, m_pcout);
`ifdef TRAP_DESALINEADO_EN
    comprobar("err_desalineado", err_desalineado, m_det);
`endif
    conc_dut = imem_req && g;
    conc_m   = exp_req && g;
    if (conc_dut) dirs.push_back(imem_dir);
    if (!rst) begin
      reset_modelo();
    end else begin
      if (rv_real) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (conc_dut) begin mem_pend = 1; mem_addr = imem_dir; mem_cnt = lat - 1; end
      if (s) begin
        tgt = ps + im;
`ifdef TRAP_DESALINEADO_EN
        if (tgt[1:0] != 2'b00) m_det = 1;
`else
        tgt[1:0] = 2'b00;
`endif
        m_pc = tgt;
        m_v = 0;
        if (m_out) begin
          if (rv) begin m_out = 0; m_disc = 0; end
          else m_disc = 1;
        end
      end else begin
        if (m_v && l) m_v = 0;
        if (m_out && rv) begin
          if (!m_disc) begin m_v = 1; m_instr = imem_dato; m_pcout = m_pend_pc; end
          m_out = 0; m_disc = 0;
        end
        if (conc_m) begin m_out = 1; m_pend_pc = m_pc; m_pc = m_pc + 64'd4; end
      end
    end
  endtask

  task automatic esperar_peticion(input string tag, input logic [63:0] esp, input int lat);
    dirs.delete();
    for (int i = 0; i < 10 && dirs.size() == 0; i++) ciclo(1, 1, 1, 0, '0, '0, lat);
    comprobar(tag, (dirs.size() > 0) ? dirs[0] : 64'bx, esp);
  endtask

  initial begin
    logic [63:0] ps, im;
    reset_L = 0; listo = 0; imem_gnt = 0; imem_rvalid = 0; salto_tomado = 0;
    pc_salto = '0; Inmediato = '0; imem_dato = '0;
    dato_fijo = 1; espurio_en = 0;
    reset_modelo();
    repeat (2) @(posedge clk);

    // Reset state, then streaming with immediate grant and 1-cycle response
    ciclo(0, 1, 1, 0, '0, '0, 1);
    dirs.delete();
    repeat (6) ciclo(1, 1, 1, 0, '0, '0, 1);
    for (int i = 0; i < 3; i++)
      comprobar($sformatf("dir_flujo%0d", i), (i < dirs.size()) ? dirs[i] : 64'bx, 64'(4 * i));
    comprobar("instr_fija", Instruccion, 64'h01400013);

    // Backpressure, then release issues a request the same cycle
    dato_fijo = 0;
    repeat (5) ciclo(1, 0, 1, 0, '0, '0, 1);
    ciclo(1, 1, 1, 0, '0, '0, 3);
    comprobar("req_tras_listo", imem_req, 1);

    // Redirect while waiting for a slow response
    ciclo(1, 1, 1, 1, 64'h10, 64'h18, 1);
    esperar_peticion("dir_salto_esperar", 64'h28, 1);

    // Redirect on the same cycle as the response
    ciclo(1, 1, 1, 1, 64'h10, 64'h18, 1);
    esperar_peticion("dir_salto_rvalid", 64'h28, 1);

    // Redirect in PEDIR with a full slot
    ciclo(1, 0, 0, 0, '0, '0, 1);
    ciclo(1, 1, 1, 1, 64'h100, 64'h20, 1);
    comprobar("req_en_salto", imem_req, 0);
    esperar_peticion("dir_salto_pedir", 64'h120, 3);

    // Reset while a request is outstanding
    ciclo(0, 1, 1, 0, '0, '0, 1);
    comprobar("req_en_reset", imem_req, 0);
    esperar_peticion("dir_tras_reset", 64'h0, 1);

    // Redirect target wrapping around 2^64
    ciclo(1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 1);
    esperar_peticion("dir_wrap", 64'h8, 1);

    // Misaligned target
    ciclo(1, 1, 0, 0, '0, '0, 1);
    ciclo(1, 1, 1, 1, 64'h0, 64'h6, 1);
`ifdef TRAP_DESALINEADO_EN
    comprobar("err_tras_salto", err_desalineado, 1);
    repeat (10) ciclo(1, 1, 1, 0, '0, '0, 1);
    comprobar("req_detenido", imem_req, 0);
`else
    esperar_peticion("dir_desalineada", 64'h4, 1);
`endif

    // Random traffic
    ciclo(0, 0, 0, 0, '0, '0, 1);
    espurio_en = 1;
    for (int n = 0; n < 400; n++) begin
      ps = {$urandom, $urandom};
      im = {$urandom, $urandom};
      if ($urandom_range(3) == 0) im = 64'($urandom_range(64));
`ifdef TRAP_DESALINEADO_EN
      ps[1:0] = 2'b00; im[1:0] = 2'b00;
`endif
      ciclo($urandom_range(99) != 0, $urandom_range(9) < 7, $urandom_range(9) < 6,
            $urandom_range(9) == 0, ps, im, int'($urandom_range(3, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fallos);
    $finish;
  end
endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
- Instruction fetch stage for the RV64 datapath, directly upstream of decode.
- Holds the PC, issues one instruction-memory request at a time and buffers the returned 32-bit word plus its PC in a one-entry IF/ID slot.
- Decode (including GeneradorImm) consumes the slot. Decode returns taken-branch redirects as branch PC + Inmediato.

Parameters:
- ANCHO_PC, 64, PC and address width.
- ANCHO_INSTR, 32, instruction width.
- PC_RESET, 64'h0, PC loaded on reset.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset_L, input, 1, synchronous active-low reset.
- imem_req, output, 1, fetch request valid.
- imem_dir, output, ANCHO_PC, fetch address; equals pc when imem_req=1.
- imem_gnt, input, 1, request accepted this cycle (imem_req && imem_gnt).
- imem_rvalid, input, 1, response valid; at least 1 cycle after the grant.
- imem_dato, input, ANCHO_INSTR, returned instruction.
- Instruccion, output, ANCHO_INSTR, IF/ID instruction to decode.
- pc_out, output, ANCHO_PC, PC of Instruccion.
- valido, output, 1, IF/ID slot holds a valid instruction.
- listo, input, 1, decode consumes the slot this cycle (valido && listo).
- salto_tomado, input, 1, redirect request from decode.
- pc_salto, input, ANCHO_PC, PC of the redirecting instruction.
- Inmediato, input, ANCHO_PC, byte offset from the immediate generator.

Behaviour:
- Reset (reset_L=0 at edge) gives:
  - pc=PC_RESET, valido=0, Instruccion=0, pc_out=0, estado=PEDIR, pc_pend=0.
  - imem_req is combinational and is 0 while reset_L=0.
- Reset mid-operation abandons any outstanding request. Memory is reset alongside this block, so no response is expected afterwards.
- An imem_rvalid arriving in PEDIR is ignored.
- Slot libre = !valido || listo.
- States: PEDIR, ESPERAR, DESCARTAR.
- PEDIR:
  - imem_req = libre && !salto_tomado.
  - On grant: pc_pend<=pc, pc<=pc+4, go to ESPERAR.
- ESPERAR:
  - imem_req=0.
  - On imem_rvalid: Instruccion<=imem_dato, pc_out<=pc_pend, valido<=1, go to PEDIR.
- DESCARTAR:
  - imem_req=0.
  - On imem_rvalid: drop the data, go to PEDIR.
- Consumption: valido && listo with no refill that cycle gives valido<=0.
- Redirect (salto_tomado=1) has priority over everything else:
  - pc <= pc_salto + Inmediato, mod 2^64, wrap-around allowed.
  - valido<=0.
  - PEDIR goes to PEDIR. No request is issued that cycle, because imem_req is gated.
  - ESPERAR without imem_rvalid goes to DESCARTAR.
  - ESPERAR with imem_rvalid in the same cycle drops the data and goes to PEDIR.
  - DESCARTAR without imem_rvalid stays in DESCARTAR with the new pc.
  - DESCARTAR with imem_rvalid goes to PEDIR.
- At most one request is outstanding at any time.
- Best-case throughput is 1 instruction per 2 cycles when gnt is immediate and rvalid comes 1 cycle later.
- The slot is always empty when a response arrives, since requests are issued only while libre.
- Target bits [1:0] are forced to 00 unless the optional feature is enabled.

Optional Feature:
- Macro: TRAP_DESALINEADO_EN.
- Defined:
  - Adds output err_desalineado (1 bit, reset 0) and state DETENIDO.
  - A redirect with (pc_salto+Inmediato)[1:0]!=0 sets err_desalineado=1 (sticky) and loads the unmodified target into pc.
  - From PEDIR it goes to DETENIDO. From ESPERAR or DESCARTAR it first waits in DESCARTAR for the pending response, then goes to DETENIDO instead of PEDIR.
  - DETENIDO: imem_req=0, valido=0; left only by reset.
- Undefined: no extra port or state; misaligned targets are forced to 00 alignment.

Decomposition:
- Package paquete_busqueda holds:
  - enum estado_busqueda_t {PEDIR, ESPERAR, DESCARTAR, DETENIDO}.
  - Constants INCREMENTO_PC=4, ANCHO_PC_DEF=64, ANCHO_INSTR_DEF=32.
- Sub-module registro_if_id: one-entry slot with load/consume/flush and valido. The FSM and PC logic stay in unidad_busqueda.

Test Plan:
- Reset then gnt immediate, rvalid +1 cycle, imem_dato=32'h01400013, listo=1:
  - imem_dir sequence is 0x0, 0x4, 0x8.
  - valido pulses with pc_out 0x0, 0x4.
  - Instruccion=32'h01400013.
- Backpressure, listo=0 with slot full:
  - imem_req stays 0 and Instruccion/pc_out stay stable.
  - Raising listo issues the next request the same cycle.
- Redirect in ESPERAR, pc_salto=0x10, Inmediato=0x18:
  - The pending response is dropped; valido stays 0.
  - Next imem_dir=0x28.
- Redirect in ESPERAR in the same cycle as rvalid:
  - The data is dropped, state goes to PEDIR, next imem_dir=0x28.
  - Redirect in PEDIR: no request that cycle, next imem_dir is the target.
- Reset_L=0 asserted while in ESPERAR:
  - One edge later pc=PC_RESET, valido=0, imem_req=0.
  - After release, the first imem_dir=PC_RESET.
- With TRAP_DESALINEADO_EN, pc_salto=0x0 and Inmediato=0x6:
  - err_desalineado=1 and state DETENIDO.
  - imem_req stays 0 until reset.
  - Without the macro, next imem_dir=0x4.
